// File: rtl/bfp_pkg.sv
// Shared widths and sequencer state type for the BFP weight-stationary multiplier.
package bfp_pkg;

  localparam int GRPSIZE       = 16;
  localparam int BFPEXPSIZE    = 8;
  localparam int BFPMANSIZE    = 4;
  localparam int MULBFPMANSIZE = (BFPMANSIZE - 1) * 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/bfp_multiplier.sv
// Combinational BFP group multiplier: exponent sum plus per-element sign/magnitude product.
module bfp_multiplier #(
  parameter int GRPSIZE       = bfp_pkg::GRPSIZE,
  parameter int BFPEXPSIZE    = bfp_pkg::BFPEXPSIZE,
  parameter int BFPMANSIZE    = bfp_pkg::BFPMANSIZE,
  parameter int MULBFPMANSIZE = bfp_pkg::MULBFPMANSIZE
) (
  input  logic [BFPEXPSIZE-1:0]            w_exp,
  input  logic [GRPSIZE*BFPMANSIZE-1:0]    w_man,
  input  logic [BFPEXPSIZE-1:0]            a_exp,
  input  logic [GRPSIZE*BFPMANSIZE-1:0]    a_man,
  output logic [BFPEXPSIZE:0]              prod_exp,
  output logic [GRPSIZE-1:0]               prod_sign,
  output logic [GRPSIZE*MULBFPMANSIZE-1:0] prod_man
);

  localparam int MAGW = BFPMANSIZE - 1;

  assign prod_exp = {1'b0, w_exp} + {1'b0, a_exp};

  // Zero magnitudes keep their XOR sign; no normalisation is applied.
  always_comb begin
    prod_sign = '0;
    prod_man  = '0;
    for (int i = 0; i < GRPSIZE; i++) begin
      prod_sign[i] = w_man[i*BFPMANSIZE + MAGW] ^ a_man[i*BFPMANSIZE + MAGW];
      prod_man[i*MULBFPMANSIZE +: MULBFPMANSIZE] =
        MULBFPMANSIZE'(w_man[i*BFPMANSIZE +: MAGW]) * MULBFPMANSIZE'(a_man[i*BFPMANSIZE +: MAGW]);
    end
  end

endmodule

// File: rtl/bfp_ws_mul_seq.sv
// Weight-stationary sequencer: holds one weight group and streams activation groups
// through the BFP multiplier into a single backpressured result register.
module bfp_ws_mul_seq
  import bfp_pkg::*;
#(
  parameter int GRPSIZE       = bfp_pkg::GRPSIZE,
  parameter int BFPEXPSIZE    = bfp_pkg::BFPEXPSIZE,
  parameter int BFPMANSIZE    = bfp_pkg::BFPMANSIZE,
  parameter int MULBFPMANSIZE = bfp_pkg::MULBFPMANSIZE,
  parameter int CNTW          = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [CNTW-1:0]                  i_num_grp,
  input  logic                             i_w_valid,
  output logic                             o_w_ready,
  input  logic [BFPEXPSIZE-1:0]            i_w_E,
  input  logic [GRPSIZE*BFPMANSIZE-1:0]    i_w_M,
  input  logic                             i_a_valid,
  output logic                             o_a_ready,
  input  logic [BFPEXPSIZE-1:0]            i_a_E,
  input  logic [GRPSIZE*BFPMANSIZE-1:0]    i_a_M,
  output logic                             o_rslt_valid,
  input  logic                             i_rslt_ready,
  output logic [GRPSIZE-1:0]               o_rslt_sign,
  output logic [BFPEXPSIZE:0]              o_rslt_exp,
  output logic [GRPSIZE*MULBFPMANSIZE-1:0] o_rslt_man,
  output logic                             o_rslt_last,
  output logic                             o_busy,
  output logic                             o_done
);

  seq_state_t                       state, state_nxt;
  logic [CNTW-1:0]                  rem;
  logic                             w_ready, a_ready, done_set;
  logic                             w_hs, a_hs, rslt_hs;

  logic [BFPEXPSIZE-1:0]            w_exp_p0;
  logic [GRPSIZE*BFPMANSIZE-1:0]    w_man_p0;
  logic [BFPEXPSIZE:0]              mul_exp;
  logic [GRPSIZE-1:0]               mul_sign;
  logic [GRPSIZE*MULBFPMANSIZE-1:0] mul_man;

  logic                             vld_p1, last_p1, done_p1;
  logic [BFPEXPSIZE:0]              rslt_exp_p1;
  logic [GRPSIZE-1:0]               rslt_sign_p1;
  logic [GRPSIZE*MULBFPMANSIZE-1:0] rslt_man_p1;

  assign w_hs    = w_ready && i_w_valid;
  assign a_hs    = a_ready && i_a_valid;
  assign rslt_hs = vld_p1 && i_rslt_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    a_ready   = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_num_grp != '0) state_nxt = LOAD_W;
          else                 done_set  = 1'b1;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (i_w_valid) state_nxt = STREAM;
      end
      STREAM: begin
        a_ready = (rem != '0) && (!vld_p1 || i_rslt_ready);
        if (a_ready && i_a_valid && rem == CNTW'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rslt_hs && last_p1) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem     <= '0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= done_set;
      if (state == IDLE && i_start) rem <= i_num_grp;
      else if (a_hs)                rem <= rem - CNTW'(1);
    end
  end

  // Stage p0: stationary weight register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_exp_p0 <= '0;
      w_man_p0 <= '0;
    end else if (w_hs) begin
      w_exp_p0 <= i_w_E;
      w_man_p0 <= i_w_M;
    end
  end

  bfp_multiplier #(
    .GRPSIZE       (GRPSIZE),
    .BFPEXPSIZE    (BFPEXPSIZE),
    .BFPMANSIZE    (BFPMANSIZE),
    .MULBFPMANSIZE (MULBFPMANSIZE)
  ) u_mul (
    .w_exp     (w_exp_p0),
    .w_man     (w_man_p0),
    .a_exp     (i_a_E),
    .a_man     (i_a_M),
    .prod_exp  (mul_exp),
    .prod_sign (mul_sign),
    .prod_man  (mul_man)
  );

  // Stage p1: result register; a new accept overwrites a result handshaken in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      rslt_exp_p1  <= '0;
      rslt_sign_p1 <= '0;
      rslt_man_p1  <= '0;
    end else if (a_hs) begin
      vld_p1       <= 1'b1;
      last_p1      <= (rem == CNTW'(1));
      rslt_exp_p1  <= mul_exp;
      rslt_sign_p1 <= mul_sign;
      rslt_man_p1  <= mul_man;
    end else if (rslt_hs) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign o_w_ready    = w_ready;
  assign o_a_ready    = a_ready;
  assign o_rslt_valid = vld_p1;
  assign o_rslt_last  = last_p1;
  assign o_rslt_exp   = rslt_exp_p1;
  assign o_rslt_sign  = rslt_sign_p1;
  assign o_rslt_man   = rslt_man_p1;
  assign o_busy       = (state != IDLE);
  assign o_done       = done_p1;

endmodule

// File: tb/tb_bfp_ws_mul_seq.sv
// Directed-plus-random bench for bfp_ws_mul_seq against a per-element arithmetic model.
module tb_bfp_ws_mul_seq;

  localparam int G  = 16;
  localparam int EW = 8;
  localparam int MW = 4;
  localparam int PW = 6;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [CW-1:0]   num_grp = '0;
  logic            w_valid = 1'b0, w_ready;
  logic [EW-1:0]   w_E = '0;
  logic [G*MW-1:0] w_M = '0;
  logic            a_valid = 1'b0, a_ready;
  logic [EW-1:0]   a_E = '0;
  logic [G*MW-1:0] a_M = '0;
  logic            rslt_valid, rslt_ready = 1'b1, rslt_last, busy, done;
  logic [G-1:0]    rslt_sign;
  logic [EW:0]     rslt_exp;
  logic [G*PW-1:0] rslt_man;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0]   we, ae;
  logic [G*MW-1:0] wm, am;
  logic [EW-1:0]   sae [4];
  logic [G*MW-1:0] sam [4];

  bfp_ws_mul_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_grp(num_grp),
    .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_E(w_E), .i_w_M(w_M),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_E(a_E), .i_a_M(a_M),
    .o_rslt_valid(rslt_valid), .i_rslt_ready(rslt_ready),
    .o_rslt_sign(rslt_sign), .o_rslt_exp(rslt_exp), .o_rslt_man(rslt_man),
    .o_rslt_last(rslt_last), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [EW:0] m_exp(logic [EW-1:0] e1, logic [EW-1:0] e2);
    int s;
    s = int'(e1) + int'(e2);
    return (EW+1)'(s);
  endfunction

  function automatic logic [G-1:0] m_sign(logic [G*MW-1:0] m1, logic [G*MW-1:0] m2);
    logic [G-1:0] r;
    r = '0;
    for (int i = 0; i < G; i++) r[i] = (m1[i*MW+3] != m2[i*MW+3]);
    return r;
  endfunction

  function automatic logic [G*PW-1:0] m_man(logic [G*MW-1:0] m1, logic [G*MW-1:0] m2);
    logic [G*PW-1:0] r;
    int v1, v2, p;
    r = '0;
    for (int i = 0; i < G; i++) begin
      v1 = int'(m1[i*MW +: 3]);
      v2 = int'(m2[i*MW +: 3]);
      if (m1[i*MW+3]) v1 = -v1;
      if (m2[i*MW+3]) v2 = -v2;
      p = v1 * v2;
      if (p < 0) p = -p;
      r[i*PW +: PW] = PW'(p);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_rslt(input string tag, input logic [EW-1:0] e1, input logic [G*MW-1:0] m1,
                          input logic [EW-1:0] e2, input logic [G*MW-1:0] m2, input logic lst);
    chk({tag, ".valid"}, 128'(rslt_valid), 128'(1'b1));
    chk({tag, ".exp"},   128'(rslt_exp),   128'(m_exp(e1, e2)));
    chk({tag, ".sign"},  128'(rslt_sign),  128'(m_sign(m1, m2)));
    chk({tag, ".man"},   128'(rslt_man),   128'(m_man(m1, m2)));
    chk({tag, ".last"},  128'(rslt_last),  128'(lst));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"},    128'(busy),       128'(0));
    chk({tag, ".w_ready"}, 128'(w_ready),    128'(0));
    chk({tag, ".a_ready"}, 128'(a_ready),    128'(0));
    chk({tag, ".valid"},   128'(rslt_valid), 128'(0));
    chk({tag, ".last"},    128'(rslt_last),  128'(0));
    chk({tag, ".done"},    128'(done),       128'(0));
    chk({tag, ".exp"},     128'(rslt_exp),   128'(0));
    chk({tag, ".sign"},    128'(rslt_sign),  128'(0));
    chk({tag, ".man"},     128'(rslt_man),   128'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_pass(input logic [CW-1:0] n, input logic [EW-1:0] e, input logic [G*MW-1:0] m);
    num_grp = n; start = 1'b1;
    tick();
    start = 1'b0;
    w_E = e; w_M = m; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
  endtask

  function automatic logic [G*MW-1:0] rnd_grp();
    return {$urandom, $urandom};
  endfunction

  initial begin
    // Reset
    tick(); tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Single group
    num_grp = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("single.busy", 128'(busy), 128'(1));
    chk("single.w_ready", 128'(w_ready), 128'(1));
    chk("single.a_ready_lw", 128'(a_ready), 128'(0));
    we = 8'd3; wm = {16{4'b0011}};
    w_E = we; w_M = wm; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    chk("single.w_ready_off", 128'(w_ready), 128'(0));
    chk("single.a_ready", 128'(a_ready), 128'(1));
    ae = 8'd5; am = {16{4'b1010}};
    a_E = ae; a_M = am; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk_rslt("single", we, wm, ae, am, 1'b1);
    chk("single.exp8", 128'(rslt_exp), 128'(9'd8));
    chk("single.sign1", 128'(rslt_sign), 128'(16'hFFFF));
    chk("single.man6", 128'(rslt_man), 128'({16{6'd6}}));
    chk("single.done_early", 128'(done), 128'(0));
    tick();
    chk("single.done", 128'(done), 128'(1));
    chk("single.busy_off", 128'(busy), 128'(0));
    chk("single.valid_off", 128'(rslt_valid), 128'(0));
    tick();
    chk("single.done_pulse", 128'(done), 128'(0));

    // Streaming four groups back-to-back
    we = 8'($urandom); wm = rnd_grp();
    begin_pass(8'd4, we, wm);
    for (int k = 0; k < 4; k++) begin
      sae[k] = 8'($urandom); sam[k] = rnd_grp();
      a_E = sae[k]; a_M = sam[k]; a_valid = 1'b1;
      #1;
      chk($sformatf("stream%0d.a_ready", k), 128'(a_ready), 128'(1));
      tick();
      chk_rslt($sformatf("stream%0d", k), we, wm, sae[k], sam[k], k == 3);
      chk($sformatf("stream%0d.busy", k), 128'(busy), 128'(1));
    end
    a_valid = 1'b0;
    chk("stream.a_ready_drain", 128'(a_ready), 128'(0));
    tick();
    chk("stream.done", 128'(done), 128'(1));
    chk("stream.busy_off", 128'(busy), 128'(0));

    // Backpressure
    we = 8'($urandom); wm = rnd_grp();
    begin_pass(8'd3, we, wm);
    rslt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sae[k] = 8'($urandom); sam[k] = rnd_grp();
    end
    a_E = sae[0]; a_M = sam[0]; a_valid = 1'b1;
    #1;
    chk("bp.a_ready0", 128'(a_ready), 128'(1));
    tick();
    chk_rslt("bp.r0", we, wm, sae[0], sam[0], 1'b0);
    a_E = sae[1]; a_M = sam[1];
    #1;
    chk("bp.a_ready_stall", 128'(a_ready), 128'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp.stall%0d.a_ready", c), 128'(a_ready), 128'(0));
      chk_rslt($sformatf("bp.stall%0d", c), we, wm, sae[0], sam[0], 1'b0);
    end
    rslt_ready = 1'b1;
    #1;
    chk("bp.a_ready_resume", 128'(a_ready), 128'(1));
    tick();
    chk_rslt("bp.r1", we, wm, sae[1], sam[1], 1'b0);
    a_E = sae[2]; a_M = sam[2];
    tick();
    chk_rslt("bp.r2", we, wm, sae[2], sam[2], 1'b1);
    a_valid = 1'b0;
    tick();
    chk("bp.done", 128'(done), 128'(1));

    // Zero count
    tick();
    num_grp = 8'd0; start = 1'b1; w_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("zero.done", 128'(done), 128'(1));
    chk("zero.busy", 128'(busy), 128'(0));
    chk("zero.w_ready", 128'(w_ready), 128'(0));
    tick();
    w_valid = 1'b0;
    chk("zero.done_pulse", 128'(done), 128'(0));
    chk("zero.busy2", 128'(busy), 128'(0));

    // Edge exponents and magnitudes
    we = 8'd255; wm = {8{8'h7F}};
    begin_pass(8'd1, we, wm);
    ae = 8'd255; am = {16{4'hF}};
    a_E = ae; a_M = am; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk_rslt("edge", we, wm, ae, am, 1'b1);
    chk("edge.exp510", 128'(rslt_exp), 128'(9'd510));
    chk("edge.man49", 128'(rslt_man), 128'({16{6'd49}}));
    tick();
    chk("edge.done", 128'(done), 128'(1));

    // Reset during STREAM with two groups remaining
    we = 8'($urandom); wm = rnd_grp();
    begin_pass(8'd3, we, wm);
    ae = 8'($urandom); am = rnd_grp();
    a_E = ae; a_M = am; a_valid = 1'b1;
    tick();
    chk_rslt("rst.pre", we, wm, ae, am, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; a_valid = 1'b0;
    chk_idle_zero("rst.post");
    tick();
    chk("rst.no_done", 128'(done), 128'(0));
    chk("rst.idle", 128'(busy), 128'(0));

    // Fresh pass after reset
    we = 8'($urandom); wm = rnd_grp();
    begin_pass(8'd2, we, wm);
    for (int k = 0; k < 2; k++) begin
      sae[k] = 8'($urandom); sam[k] = rnd_grp();
      a_E = sae[k]; a_M = sam[k]; a_valid = 1'b1;
      tick();
      chk_rslt($sformatf("fresh%0d", k), we, wm, sae[k], sam[k], k == 1);
    end
    a_valid = 1'b0;
    tick();
    chk("fresh.done", 128'(done), 128'(1));
    chk("fresh.busy_off", 128'(busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
